// File: rtl/sinc_filter_poly_matrix_gen.sv
// Farrow coefficient matrix generator for a fractional-delay sinc filter.
// For every tap t the prototype h(mu,t) = w(t)*sinc((t-(TAPS/2-1)-mu)*SPAN/TAPS)
// is sampled at mu = f/FILTERS and fitted by a least-squares polynomial of
// degree DEGREE. The fit uses normal equations and Gaussian elimination with
// partial pivoting. One tap column is produced per clock while busy.
// Optional macro: SINC_WINDOW_EN selects a Blackman window. When it is
// undefined, a rectangular window is used.
module sinc_filter_poly_matrix_gen #(
  parameter int FILTERS = 40,
  parameter int TAPS    = 12,
  parameter int SPAN    = TAPS,
  parameter int DEGREE  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output real  polyM [DEGREE+1][TAPS]
);

  localparam real PI     = 3.14159265358979323846;
  localparam real SCALE  = real'(SPAN) / real'(TAPS);
  localparam int  CENTER = TAPS / 2 - 1;
  localparam int  TW     = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam int  NR     = DEGREE + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Reject parameter sets the fit cannot handle.
  if (DEGREE + 1 > FILTERS || TAPS < 2 || SPAN <= 0) begin : g_param_check
    $fatal(1, "sinc_filter_poly_matrix_gen: illegal FILTERS/TAPS/SPAN/DEGREE");
  end

  logic [1:0]    state;
  logic [TW-1:0] tap;

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real window(input int t);
`ifdef SINC_WINDOW_EN
    real ph;
    ph = (real'(t) + 0.5) / real'(TAPS);
    return 0.42 - 0.5 * $cos(2.0 * PI * ph) + 0.08 * $cos(4.0 * PI * ph);
`else
    return (t >= 0) ? 1.0 : 1.0;
`endif
  endfunction

  function automatic real sinc(input real x);
    if (x > -1.0e-12 && x < 1.0e-12) return 1.0;
    return $sin(PI * x) / (PI * x);
  endfunction

  function automatic real proto(input int f, input int t);
    real mu;
    real x;
    mu = real'(f) / real'(FILTERS);
    x  = (real'(t - CENTER) - mu) * SCALE;
    return window(t) * sinc(x);
  endfunction

  // Least-squares coefficient of mu^k for tap t. The augmented normal matrix
  // is rebuilt on every call, which keeps the function free of shared state.
  function automatic real fit_coef(input int t, input int k);
    real a  [NR][NR+1];
    real pw [2*DEGREE+1];
    real c  [NR];
    real mu, h, m, s, tmp;
    int  piv;
    for (int i = 0; i < NR; i++) begin
      c[i] = 0.0;
      for (int j = 0; j <= NR; j++) a[i][j] = 0.0;
    end
    for (int f = 0; f < FILTERS; f++) begin
      mu    = real'(f) / real'(FILTERS);
      h     = proto(f, t);
      pw[0] = 1.0;
      for (int n = 1; n <= 2 * DEGREE; n++) pw[n] = pw[n-1] * mu;
      for (int i = 0; i < NR; i++) begin
        for (int j = 0; j < NR; j++) a[i][j] = a[i][j] + pw[i+j];
        a[i][NR] = a[i][NR] + pw[i] * h;
      end
    end
    for (int col = 0; col < NR; col++) begin
      piv = col;
      for (int r = col + 1; r < NR; r++)
        if (rabs(a[r][col]) > rabs(a[piv][col])) piv = r;
      if (piv != col) begin
        for (int j = 0; j <= NR; j++) begin
          tmp        = a[col][j];
          a[col][j]  = a[piv][j];
          a[piv][j]  = tmp;
        end
      end
      for (int r = col + 1; r < NR; r++) begin
        m = a[r][col] / a[col][col];
        for (int j = col; j <= NR; j++) a[r][j] = a[r][j] - m * a[col][j];
      end
    end
    for (int i = NR - 1; i >= 0; i--) begin
      s = a[i][NR];
      for (int j = i + 1; j < NR; j++) s = s - a[i][j] * c[j];
      c[i] = s / a[i][i];
    end
    return c[k];
  endfunction

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

  // Control FSM and matrix storage. Each accepted start wipes the matrix, so
  // columns not yet computed read as zero while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tap   <= '0;
      for (int k = 0; k < NR; k++)
        for (int t = 0; t < TAPS; t++) polyM[k][t] <= 0.0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_BUSY;
            tap   <= '0;
            for (int k = 0; k < NR; k++)
              for (int t = 0; t < TAPS; t++) polyM[k][t] <= 0.0;
          end
        end
        S_BUSY: begin
          for (int k = 0; k < NR; k++) polyM[k][tap] <= fit_coef(int'(tap), k);
          if (tap == TW'(TAPS - 1)) begin
            state <= S_DONE;
            tap   <= '0;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sinc_filter_poly_matrix_gen.sv
// Directed bench for sinc_filter_poly_matrix_gen with default parameters:
// reset, latency, mu=0 / mu=1 fit values, restart, start re-pulse,
// mid-operation reset and reset-over-start priority.
module tb_sinc_filter_poly_matrix_gen;

  localparam int  FILTERS = 40;
  localparam int  TAPS    = 12;
  localparam int  DEGREE  = 5;
  localparam real PI      = 3.14159265358979323846;

  logic clk, rst, start, busy, done;
  real  poly_m  [DEGREE+1][TAPS];
  real  ref_m   [DEGREE+1][TAPS];
  int   checks, errors;
  real  sum5, sum6, w5, w6;

  sinc_filter_poly_matrix_gen #(
    .FILTERS(FILTERS), .TAPS(TAPS), .SPAN(TAPS), .DEGREE(DEGREE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .polyM(poly_m)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real blackman(input int t);
    real ph;
    ph = (real'(t) + 0.5) / real'(TAPS);
    return 0.42 - 0.5 * $cos(2.0 * PI * ph) + 0.08 * $cos(4.0 * PI * ph);
  endfunction

  function automatic int count_nonzero();
    int n;
    n = 0;
    for (int k = 0; k <= DEGREE; k++)
      for (int t = 0; t < TAPS; t++)
        if (poly_m[k][t] != 0.0) n++;
    return n;
  endfunction

  function automatic int count_diff();
    int n;
    n = 0;
    for (int k = 0; k <= DEGREE; k++)
      for (int t = 0; t < TAPS; t++)
        if (poly_m[k][t] != ref_m[k][t]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_real(input string tag, input real obs, input real exp, input real tol);
    logic ok;
    ok = (rabs(obs - exp) <= tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %f expected %f tol %f", tag, obs, exp, tol);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    start  = 1'b0;
`ifdef SINC_WINDOW_EN
    w5 = blackman(5);
    w6 = blackman(6);
`else
    w5 = 1.0;
    w6 = 1.0;
`endif

    // Reset for two clocks.
    tick();
    tick();
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_int("rst_matrix_zero", count_nonzero(), 0);
    rst = 1'b0;
    tick();
    check_bit("idle_busy", busy, 1'b0);

    // First computation: busy for 12 clocks, then done.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_bit("start_busy", busy, 1'b1);
    check_bit("start_done", done, 1'b0);
    check_int("start_matrix_zero", count_nonzero(), 0);
    for (int i = 1; i < TAPS; i++) begin
      tick();
      check_bit("run_busy", busy, 1'b1);
      check_bit("run_done", done, 1'b0);
      if (i == 3) check_real("uncomputed_col", poly_m[0][11], 0.0, 0.0);
    end
    tick();
    check_bit("lat_done", done, 1'b1);
    check_bit("lat_busy", busy, 1'b0);

    // mu = 0: only the centre tap is nonzero.
    for (int t = 0; t < TAPS; t++)
      check_real($sformatf("mu0_tap%0d", t), poly_m[0][t], (t == 5) ? w5 : 0.0, 1.0e-3);

    // mu = 1: column sums evaluate the polynomial at mu = 1.
    sum5 = 0.0;
    sum6 = 0.0;
    for (int k = 0; k <= DEGREE; k++) begin
      sum5 += poly_m[k][5];
      sum6 += poly_m[k][6];
    end
    check_real("mu1_tap6", sum6, w6, 1.0e-2);
    check_real("mu1_tap5", sum5, 0.0, 1.0e-2);
    for (int k = 0; k <= DEGREE; k++)
      for (int t = 0; t < TAPS; t++) ref_m[k][t] = poly_m[k][t];

    tick();
    tick();
    check_bit("done_held", done, 1'b1);

    // Restart from DONE, with start re-pulsed at clock 3 of BUSY.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_bit("restart_busy", busy, 1'b1);
    check_int("restart_cleared", count_nonzero(), 0);
    for (int i = 1; i < TAPS; i++) begin
      tick();
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      check_bit("repulse_done", done, 1'b0);
    end
    tick();
    check_bit("repulse_lat_done", done, 1'b1);
    check_int("restart_identical", count_diff(), 0);

    // Reset five clocks after start aborts the run.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check_int("abort_matrix_zero", count_nonzero(), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < TAPS; i++) tick();
    check_bit("post_abort_early", done, 1'b0);
    tick();
    check_bit("post_abort_done", done, 1'b1);
    check_int("post_abort_identical", count_diff(), 0);

    // Reset wins over start on the same edge.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_bit("prio_busy", busy, 1'b0);
    check_bit("prio_done", done, 1'b0);
    tick();
    check_bit("prio_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
